l2_invq: RTL and testbench
==========================

// Module: l2_invq
// PURPOSE
//  Multi-channel L2 invalidation queue; successor to the fixed 26-bit x 8 invalidation FIFO.
//  Buffers line addresses from l2tag and broadcasts each one to NCH L1 invalidation channels.
//  Each channel has its own ready. An entry retires only when every channel has accepted it.
//  Sits between l2tag (l2tag_inv_valid/addr) and the per-core L1 invalidation ports.
// PARAMETERS
//  AW     26  address width (line address bits [31:6])
//  DEPTH  8   entry count; power of 2, >=2
//  NCH    2   number of invalidation consumer channels, >=1
// PORTS
//  clk       in   1                   clock
//  rst       in   1                   synchronous active-high reset
//  wr_valid  in   1                   enqueue request from l2tag
//  wr_addr   in   AW                  line address to invalidate
//  wr_ready  out  1                   enqueue accepted when wr_valid&&wr_ready
//  rd_valid  out  NCH                 per-channel head-entry valid
//  rd_addr   out  AW                  head-entry address, shared by all channels
//  rd_ready  in   NCH                 per-channel accept
//  count     out  $clog2(DEPTH+1)     number of occupied entries
// BEHAVIOUR
//  - Interface: one clock (clk); reset (rst) is synchronous and active-high.
//  - Storage:
//    - Circular buffer with head/tail pointers of $clog2(DEPTH) bits; both wrap DEPTH-1 -> 0.
//    - Registered count; full = (count==DEPTH), empty = (count==0).
//  - Reset values: head=tail=0, count=0, done mask=0, rd_valid=0, rd_addr=0, wr_ready=1.
//    Entry storage contents are not reset.
//  - Push:
//    - wr_ready = !full; it does NOT account for a same-cycle pop.
//    - Push writes mem[tail] and advances tail.
//    - Latency: a push into an empty queue gives rd_valid the next cycle.
//  - Broadcast and pop:
//    - rd_valid[i] = !empty && !done[i]; rd_addr = empty ? 0 : mem[head].
//    - A handshake rd_valid[i]&&rd_ready[i] sets done[i] at the clock edge.
//    - The head pops in the cycle where (done | handshakes) == all-ones. On pop, head advances
//      and done clears to 0, so the next entry is offered to all channels the following cycle.
//    - A channel that has accepted keeps rd_valid[i]=0 until the pop; rd_ready[i] is then ignored.
//    - NCH=1 behaves exactly as a plain FIFO; done stays 0.
//  - Simultaneous events:
//    - Push and pop in the same cycle: count is unchanged, both pointers advance.
//    - Pop when count==1 together with a push: the queue is non-empty next cycle and holds the
//      new entry with done=0.
//  - Full: writes are back-pressured and no entry is overwritten.
//  - Empty: no pop occurs and done is held at 0.
//  - Reset mid-operation: all pending entries and partial deliveries are discarded.
//  - Assertions (sim only): no push when full, no pop when empty, count<=DEPTH.
// CONFIGURATION
//  L2INVQ_COALESCE_EN defined:
//    - Compare wr_addr against every valid entry except the head.
//    - On a match, set wr_ready=1 even when full; the write is absorbed with no state change.
//    - The head is excluded because it may be partially delivered.
//    - This makes wr_ready combinationally dependent on wr_addr.
//  L2INVQ_COALESCE_EN undefined: every accepted write allocates an entry; no comparators.
// TESTING
//  - Reset, then push 0x1234567 with NCH=2 -> next cycle rd_valid=2'b11, rd_addr=0x1234567,
//    count=1.
//  - rd_ready=2'b01, then 2'b10 on the next cycle -> rd_valid goes 11 -> 10 -> 00 and count
//    goes 1 -> 1 -> 0.
//  - Push 8 distinct addresses, rd_ready=0 -> wr_ready=0 when count=8.
//    A 9th push stalls; the FIFO order of the first 8 is preserved through wrap.
//  - count=1, pop and push 0xABC in the same cycle -> count stays 1, rd_addr=0xABC, done=0.
//  - COALESCE_EN, queue holds A(head), B; push B -> absorbed, count stays 2.
//    Push A -> allocates, count=3.
//  - Assert rst with 3 entries and one channel done -> next cycle count=0, rd_valid=0,
//    wr_ready=1.

Source files
------------

// File: rtl/l2_invq.sv
// l2_invq: multi-channel L2 invalidation queue.
// Buffers line addresses from l2tag and broadcasts the head entry to NCH L1 invalidation
// channels. The head retires once every channel has accepted it.
// Optional feature macro: L2INVQ_COALESCE_EN absorbs a write whose address already sits in a
// non-head valid entry.
module l2_invq #(
    parameter int unsigned AW    = 26,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned NCH   = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_valid_i,
    input  logic [AW-1:0]              wr_addr_i,
    output logic                       wr_ready_o,
    output logic [NCH-1:0]             rd_valid_o,
    output logic [AW-1:0]              rd_addr_o,
    input  logic [NCH-1:0]             rd_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0]  mem_q [DEPTH];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic [NCH-1:0] done_q, done_d;

    logic           full, empty, hit, push, pop;
    logic [NCH-1:0] hs;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

`ifdef L2INVQ_COALESCE_EN
    // Distance of slot i from the head, modulo DEPTH.
    function automatic logic [PW-1:0] slot_off(input int unsigned i, input logic [PW-1:0] head);
        return PW'(i) - head;
    endfunction

    // Match wr_addr against every valid entry except the head (it may be partially delivered).
    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((slot_off(i, head_q) != '0) && (CW'(slot_off(i, head_q)) < count_q) &&
                (mem_q[i] == wr_addr_i)) begin
                hit = 1'b1;
            end
        end
    end
`else
    assign hit = 1'b0;
`endif

    // A coalesced write is accepted but allocates nothing.
    assign wr_ready_o = !full || hit;
    assign push       = wr_valid_i && wr_ready_o && !hit;

    assign rd_valid_o = empty ? '0 : ~done_q;
    assign rd_addr_o  = empty ? '0 : mem_q[head_q];
    assign count_o    = count_q;

    assign hs  = rd_valid_o & rd_ready_i;
    assign pop = !empty && (&(done_q | hs));

    // Next-state for pointers, occupancy and the per-channel delivered mask.
    always_comb begin
        head_d  = pop ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        done_d = (pop || empty) ? '0 : (done_q | hs);
    end

    // Control state with synchronous reset; pending entries are discarded on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Entry storage, intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[tail_q] <= wr_addr_i;
        end
    end

`ifndef SYNTHESIS
    // Occupancy sanity checks.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && full));
            assert (!(pop && empty));
            assert (count_q <= CW'(DEPTH));
        end
    end
`endif

endmodule

// File: tb/tb_l2_invq.sv
// Self-checking bench for l2_invq (AW=26, DEPTH=8, NCH=2) against a queue-based reference.
module tb_l2_invq;

    localparam int unsigned AW    = 26;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned NCH   = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          wr_valid_i = 1'b0;
    logic [AW-1:0] wr_addr_i = '0;
    logic          wr_ready_o;
    logic [NCH-1:0] rd_valid_o;
    logic [AW-1:0] rd_addr_o;
    logic [NCH-1:0] rd_ready_i = '0;
    logic [3:0]    count_o;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0]  q[$];
    logic [NCH-1:0] dn = '0;

    l2_invq #(.AW(AW), .DEPTH(DEPTH), .NCH(NCH)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_valid_i (wr_valid_i),
        .wr_addr_i  (wr_addr_i),
        .wr_ready_o (wr_ready_o),
        .rd_valid_o (rd_valid_o),
        .rd_addr_o  (rd_addr_o),
        .rd_ready_i (rd_ready_i),
        .count_o    (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs at the falling edge, then advance the model.
    task automatic step(input logic r, input logic wv, input logic [AW-1:0] wa,
                        input logic [NCH-1:0] rr);
        logic           match, pop, push;
        logic [NCH-1:0] ev, hs;
        logic [31:0]    ea;
        rst_i = r;
        wr_valid_i = wv;
        wr_addr_i = wa;
        rd_ready_i = rr;
        @(negedge clk_i);
        match = 1'b0;
`ifdef L2INVQ_COALESCE_EN
        for (int i = 1; i < q.size(); i++) if (q[i] == wa) match = 1'b1;
`endif
        ev = (q.size() > 0) ? ~dn : '0;
        ea = (q.size() > 0) ? 32'(q[0]) : 32'd0;
        chk("count", 32'(count_o), 32'(q.size()));
        chk("rd_valid", 32'(rd_valid_o), 32'(ev));
        chk("rd_addr", 32'(rd_addr_o), ea);
        chk("wr_ready", 32'(wr_ready_o), 32'((q.size() < DEPTH) || match));
        @(posedge clk_i);
        if (r) begin
            q.delete();
            dn = '0;
        end else begin
            hs = ev & rr;
            pop = (q.size() > 0) && ((dn | hs) == '1);
            push = wv && (q.size() < DEPTH) && !match;
            if (pop) begin
                void'(q.pop_front());
                dn = '0;
            end else begin
                dn = dn | hs;
            end
            if (push) q.push_back(wa);
        end
        #1;
    endtask

    initial begin
        logic [NCH-1:0] rr;
        repeat (2) @(posedge clk_i);
        #1;

        // Reset state, then a single push delivered to both channels in turn.
        step(1'b0, 1'b0, '0, 2'b00);
        step(1'b0, 1'b1, 26'h1234567, 2'b00);
        step(1'b0, 1'b0, '0, 2'b01);
        step(1'b0, 1'b0, '0, 2'b10);
        step(1'b0, 1'b0, '0, 2'b00);

        // Fill to full, try a 9th push, then drain in order across the pointer wrap.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, AW'(32'h100 + i), 2'b00);
        step(1'b0, 1'b0, '0, 2'b00);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 2'b11);
        step(1'b0, 1'b0, '0, 2'b00);

        // Pop at count==1 together with a push.
        step(1'b0, 1'b1, 26'h55, 2'b00);
        step(1'b0, 1'b1, 26'hABC, 2'b11);
        step(1'b0, 1'b0, '0, 2'b00);
        step(1'b0, 1'b0, '0, 2'b11);

        // Re-push of a non-head entry (absorbed when coalescing) and of the head.
        step(1'b0, 1'b1, 26'hA, 2'b00);
        step(1'b0, 1'b1, 26'hB, 2'b00);
        step(1'b0, 1'b1, 26'hB, 2'b00);
        step(1'b0, 1'b1, 26'hA, 2'b00);
        step(1'b0, 1'b0, '0, 2'b00);
`ifdef L2INVQ_COALESCE_EN
        chk("coalesce_count", 32'(count_o), 32'd3);
`else
        chk("alloc_count", 32'(count_o), 32'd4);
`endif

        // Reset with a partially delivered head and pending entries.
        step(1'b1, 1'b0, '0, 2'b00);
        step(1'b0, 1'b1, 26'h11, 2'b00);
        step(1'b0, 1'b1, 26'h22, 2'b00);
        step(1'b0, 1'b1, 26'h33, 2'b00);
        step(1'b0, 1'b0, '0, 2'b01);
        step(1'b1, 1'b1, 26'h44, 2'b00);
        step(1'b0, 1'b0, '0, 2'b00);
        chk("post_reset_count", 32'(count_o), 32'd0);

        // Random traffic, alternating drain-heavy and fill-heavy phases.
        for (int k = 0; k < 800; k++) begin
            rr = NCH'($urandom);
            if (((k / 100) % 2) == 1 && ($urandom % 4) != 0) rr = '0;
            step(($urandom % 200) == 0, 1'($urandom), AW'($urandom_range(0, 11)), rr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
